// File: rtl/contador_pkg.sv
// Shared types and sizes for the PWM dimmer: a 4-bit level spread over 16 slots.
package contador_pkg;
  localparam int DUTY_W = 4;
  localparam int SLOTS  = 16;

  typedef enum logic {IDLE, RUN} dimmer_state_t;
  typedef logic [DUTY_W-1:0] level_t;
endpackage

// File: rtl/pwm_prescaler.sv
// Slot-rate divider: counts 0..PRESCALE-1 while en is high and flags the last count.
// clear has priority over en and returns the count to 0.
module pwm_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic tick
);
  localparam logic [7:0] LAST = 8'(PRESCALE - 1);

  logic [7:0] r_cnt;

  assign tick = en && (r_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= tick ? 8'd0 : r_cnt + 8'd1;
    end
  end
endmodule

// File: rtl/pwm_dimmer.sv
// 16-slot PWM from a 4-bit level latched only at period boundaries, with peak/valley
// detection of the upstream sweep direction.
module pwm_dimmer
  import contador_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty_in,
  output logic              pwm_out,
  output logic [DUTY_W-1:0] duty_q,
  output logic              period_start,
  output logic              peak,
  output logic              valley
);
  dimmer_state_t r_state, w_state_nxt;
  level_t        r_slot, w_slot_nxt;
  level_t        r_duty_q, w_duty_q_nxt;
  logic          r_period_start, w_period_start_nxt;
  logic          r_peak, w_peak_nxt;
  logic          r_valley, w_valley_nxt;
  logic          r_prev_valid, w_prev_valid_nxt;
  logic          r_trend_valid, w_trend_valid_nxt;
  logic          r_rising, w_rising_nxt;
  logic          w_run;
  logic          w_slot_tick;

  assign w_run = (r_state == RUN);

  pwm_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clear(!(w_run && enable)),
    .en   (w_run),
    .tick (w_slot_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_slot         <= '0;
      r_duty_q       <= '0;
      r_period_start <= 1'b0;
      r_peak         <= 1'b0;
      r_valley       <= 1'b0;
      r_prev_valid   <= 1'b0;
      r_trend_valid  <= 1'b0;
      r_rising       <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_slot         <= w_slot_nxt;
      r_duty_q       <= w_duty_q_nxt;
      r_period_start <= w_period_start_nxt;
      r_peak         <= w_peak_nxt;
      r_valley       <= w_valley_nxt;
      r_prev_valid   <= w_prev_valid_nxt;
      r_trend_valid  <= w_trend_valid_nxt;
      r_rising       <= w_rising_nxt;
    end
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_slot_nxt         = r_slot;
    w_duty_q_nxt       = r_duty_q;
    w_period_start_nxt = 1'b0;
    w_peak_nxt         = 1'b0;
    w_valley_nxt       = 1'b0;
    w_prev_valid_nxt   = r_prev_valid;
    w_trend_valid_nxt  = r_trend_valid;
    w_rising_nxt       = r_rising;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt        = RUN;
          w_duty_q_nxt       = duty_in;
          w_slot_nxt         = '0;
          w_period_start_nxt = 1'b1;
          w_prev_valid_nxt   = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          w_state_nxt       = IDLE;
          w_slot_nxt        = '0;
          w_prev_valid_nxt  = 1'b0;
          w_trend_valid_nxt = 1'b0;
        end else if (w_slot_tick) begin
          w_slot_nxt = r_slot + 4'd1;
          if (r_slot == level_t'(SLOTS - 1)) begin
            w_duty_q_nxt       = duty_in;
            w_period_start_nxt = 1'b1;
            // Equal levels leave the trend untouched so the counter's end-stop hold is ignored.
            if (r_prev_valid && (duty_in > r_duty_q)) begin
              w_valley_nxt      = r_trend_valid && !r_rising;
              w_rising_nxt      = 1'b1;
              w_trend_valid_nxt = 1'b1;
            end else if (r_prev_valid && (duty_in < r_duty_q)) begin
              w_peak_nxt        = r_trend_valid && r_rising;
              w_rising_nxt      = 1'b0;
              w_trend_valid_nxt = 1'b1;
            end
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign pwm_out      = w_run && (r_slot < r_duty_q);
  assign duty_q       = r_duty_q;
  assign period_start = r_period_start;
  assign peak         = r_peak;
  assign valley       = r_valley;
endmodule
